mmio_sram_slave: RTL and testbench
==================================

MMIO_SRAM_SLAVE -- requirements
Module: mmio_sram_slave

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port en, input, 1 bit: access request from CPU data port.
REQ-004 The block SHALL have port wen, input, 4 bits: byte write enables; wen[i] covers wdata[8i+7:8i]; 4'b0000 with en=1 is a read.
REQ-005 The block SHALL have port addr, input, 32 bits: byte address; only addr[15:2] decoded, addr[31:16] and addr[1:0] ignored.
REQ-006 The block SHALL have port wdata, input, 32 bits: write data.
REQ-007 The block SHALL have port rdata, output, 32 bits: registered read data.
REQ-008 The block SHALL have port switch, input, 16 bits: asynchronous board switches.
REQ-009 The block SHALL have port led, output, 16 bits: LED register value.
REQ-010 The block SHALL have port timer_irq, output, 1 bit: timer match flag.

Function
REQ-011 Register map (offset = addr[15:0]) SHALL be: 0x0000 SCRATCH0 RW; 0x0004 SCRATCH1 RW; 0x8000 TIMER RW; 0x8004 TIMER_CMP RW; 0x8008 TIMER_STAT (bit0 MATCH, W1C, bits[31:1] read 0); 0xF000 LED RW (bits[15:0], bits[31:16] read 0, writes ignored); 0xF004 SWITCH RO (bits[15:0]).
REQ-012 Read latency SHALL be exactly 1 cycle: when en=1 at edge N, rdata after edge N holds the addressed register value sampled before edge N's updates.
REQ-013 rdata SHALL update on every edge with en=1, including write cycles (read-before-write old value), and SHALL hold its value on edges with en=0.
REQ-014 Unmapped offsets SHALL read 32'h0; writes to them and to SWITCH SHALL be ignored.
REQ-015 Writes SHALL be byte-masked: only lanes with wen[i]=1 change; unselected lanes keep their value.
REQ-016 TIMER SHALL increment by 1 every cycle, wrapping 32'hFFFFFFFF -> 32'h0.
REQ-017 On a TIMER write cycle, written lanes SHALL take wdata and unwritten lanes SHALL take the current (non-incremented) value; no increment that cycle.
REQ-018 MATCH SHALL be set on the edge after any cycle where TIMER == TIMER_CMP (pre-update values compared).
REQ-019 Writing TIMER_STAT with wen[0]=1 and wdata[0]=1 SHALL clear MATCH; if set and clear coincide, set SHALL win.
REQ-020 timer_irq SHALL equal MATCH directly.
REQ-021 switch SHALL pass through a 2-flop synchronizer; SWITCH reads and all logic use the second flop; 2-cycle input-to-register latency.
REQ-022 led SHALL be driven directly from the LED register.
REQ-023 No back-pressure: every en=1 cycle is accepted; back-to-back accesses on consecutive cycles SHALL each complete per REQ-012.

Reset
REQ-024 With rst=1 at an edge: SCRATCH0/1, TIMER, LED, MATCH, rdata, synchronizer flops SHALL become 0; TIMER_CMP SHALL become 32'hFFFFFFFF.
REQ-025 Reset SHALL override any concurrent access; an access presented with rst=1 is discarded and produces no rdata.
REQ-026 After rst falls, TIMER SHALL read 0 at first post-reset edge, then count; timer_irq SHALL stay 0 until TIMER reaches TIMER_CMP.

Verification
REQ-027 Byte write: write SCRATCH0=32'h11223344 wen=4'hF, then wdata=32'hAABBCCDD wen=4'b0101 -> read returns 32'h11BB33DD one cycle after request.
REQ-028 Read-before-write: SCRATCH1=5, write 9 -> rdata after write edge = 5; next read -> 9.
REQ-029 Timer match/clear: write TIMER=0, TIMER_CMP=10 -> timer_irq rises 11 edges after TIMER write takes effect; W1C write to 0x8008 -> timer_irq 0 next cycle; concurrent match and clear -> stays 1.
REQ-030 Wrap: write TIMER=32'hFFFFFFFE -> reads 32'hFFFFFFFF then 32'h00000000 on consecutive cycles (accounting for 1-cycle latency).
REQ-031 Switch/LED/unmapped: switch=16'hA5A5 -> SWITCH read 16'hA5A5 no earlier than 2 cycles later; write LED=32'hFFFF1234 -> led=16'h1234, read 32'h00001234; read 0x4000 -> 0.
REQ-032 Mid-operation reset: assert rst during write to LED and timer running -> led=0, TIMER=0, TIMER_CMP=32'hFFFFFFFF, rdata=0, timer_irq=0.

Source files
------------

// File: rtl/mmio_sram_slave.sv
// mmio_sram_slave: memory-mapped scratch, timer, LED and switch registers with 1-cycle read latency
module mmio_sram_slave (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [15:0] switch,
    output logic [15:0] led,
    output logic        timer_irq
);
    logic [31:0] scratch0, scratch1, timer, timer_cmp, rd_val, mask;
    logic [15:0] sw_meta, sw_sync;
    logic [13:0] word;
    logic        match, wr, hit, clr;
    logic        sel_s0, sel_s1, sel_tmr, sel_cmp, sel_stat, sel_led, sel_sw;
    logic        unused_addr;

    assign unused_addr = ^{addr[31:16], addr[1:0]};
    assign timer_irq   = match;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
        return (old & ~m) | (d & m);
    endfunction

    // address decode, byte-lane mask, match/clear terms and read mux
    always_comb begin
        word     = addr[15:2];
        sel_s0   = word == 14'h0000;
        sel_s1   = word == 14'h0001;
        sel_tmr  = word == 14'h2000;
        sel_cmp  = word == 14'h2001;
        sel_stat = word == 14'h2002;
        sel_led  = word == 14'h3C00;
        sel_sw   = word == 14'h3C01;
        wr       = en && (wen != 4'b0000);
        mask     = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
        hit      = timer == timer_cmp;
        clr      = wr && sel_stat && wen[0] && wdata[0];
        rd_val   = sel_s0   ? scratch0 :
                   sel_s1   ? scratch1 :
                   sel_tmr  ? timer :
                   sel_cmp  ? timer_cmp :
                   sel_stat ? {31'h0, match} :
                   sel_led  ? {16'h0, led} :
                   sel_sw   ? {16'h0, sw_sync} : 32'h0;
    end

    // register state: reads sample pre-edge values, writes are byte-masked, timer free-runs
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch0  <= 32'h0;
            scratch1  <= 32'h0;
            timer     <= 32'h0;
            timer_cmp <= 32'hFFFF_FFFF;
            match     <= 1'b0;
            led       <= 16'h0;
            rdata     <= 32'h0;
            sw_meta   <= 16'h0;
            sw_sync   <= 16'h0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
            if (en) rdata <= rd_val;
            if (wr && sel_s0) scratch0 <= merge(scratch0, wdata, mask);
            if (wr && sel_s1) scratch1 <= merge(scratch1, wdata, mask);
            if (wr && sel_cmp) timer_cmp <= merge(timer_cmp, wdata, mask);
            if (wr && sel_led) led <= (led & ~mask[15:0]) | (wdata[15:0] & mask[15:0]);
            timer <= (wr && sel_tmr) ? merge(timer, wdata, mask) : timer + 32'd1;
            match <= hit || (match && !clr);
        end
    end
endmodule

// File: tb/tb_mmio_sram_slave.sv
// tb_mmio_sram_slave: directed checks of the MMIO register block
module tb_mmio_sram_slave;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, timer_irq;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0, rdata, r;
    logic [15:0] switch = 16'h0, led;
    int tests = 0, fails = 0;

    localparam logic [31:0] S0 = 32'h0000, S1 = 32'h0004, TMR = 32'h8000, CMP = 32'h8004,
                            STAT = 32'h8008, LED = 32'hF000, SW = 32'hF004;

    mmio_sram_slave dut (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata), .switch(switch), .led(led), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        en = 1'b1; wen = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        en = 1'b0; wen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        en = 1'b1; wen = 4'h0; addr = a;
        @(posedge clk);
        #1;
        en = 1'b0;
        d = rdata;
    endtask

    initial begin
        idle(2);
        check("rst_rdata", rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        rst = 1'b0;
        rd(TMR, r);     check("timer_first", r, 32'h0);
        rd(CMP, r);     check("cmp_reset", r, 32'hFFFF_FFFF);
        rd(S0, r);      check("s0_reset", r, 32'h0);

        wr(S0, 32'h1122_3344, 4'hF);
        wr(S0, 32'hAABB_CCDD, 4'b0101);
        check("s0_rbw", rdata, 32'h1122_3344);
        rd(S0, r);      check("s0_bytes", r, 32'h11BB_33DD);
        rd(32'hDEAD_0001, r); check("s0_alias", r, 32'h11BB_33DD);

        wr(S1, 32'd5, 4'hF);
        wr(S1, 32'd9, 4'hF);
        check("s1_rbw", rdata, 32'd5);
        rd(S1, r);      check("s1_new", r, 32'd9);
        idle(2);
        check("rdata_hold", rdata, 32'd9);

        wr(TMR, 32'd0, 4'hF);
        wr(CMP, 32'd10, 4'hF);
        idle(9);
        check("irq_before", {31'h0, timer_irq}, 32'h0);
        idle(1);
        check("irq_rise", {31'h0, timer_irq}, 32'h1);
        wr(STAT, 32'h1, 4'b0001);
        check("stat_read", rdata, 32'h1);
        check("irq_clear", {31'h0, timer_irq}, 32'h0);

        wr(CMP, 32'd200, 4'hF);
        wr(TMR, 32'd199, 4'hF);
        idle(1);
        wr(TMR, 32'd200, 4'hF);
        check("irq_set2", {31'h0, timer_irq}, 32'h1);
        wr(STAT, 32'h1, 4'b0001);
        check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
        wr(STAT, 32'h1, 4'b0001);
        check("irq_clear2", {31'h0, timer_irq}, 32'h0);

        wr(TMR, 32'h1234_5678, 4'hF);
        wr(TMR, 32'h0000_00AA, 4'b0001);
        rd(TMR, r);     check("timer_partial", r, 32'h1234_56AA);

        wr(TMR, 32'hFFFF_FFFE, 4'hF);
        rd(TMR, r);     check("wrap_fe", r, 32'hFFFF_FFFE);
        rd(TMR, r);     check("wrap_ff", r, 32'hFFFF_FFFF);
        rd(TMR, r);     check("wrap_00", r, 32'h0);

        switch = 16'hA5A5;
        rd(SW, r);      check("sw_lat1", r, 32'h0);
        rd(SW, r);      check("sw_lat2", r, 32'h0);
        rd(SW, r);      check("sw_sync", r, 32'h0000_A5A5);
        wr(SW, 32'hFFFF_FFFF, 4'hF);
        rd(SW, r);      check("sw_ro", r, 32'h0000_A5A5);

        wr(LED, 32'hFFFF_1234, 4'hF);
        check("led_port", {16'h0, led}, 32'h0000_1234);
        rd(LED, r);     check("led_read", r, 32'h0000_1234);
        wr(32'h4000, 32'hDEAD_BEEF, 4'hF);
        rd(32'h4000, r); check("unmapped", r, 32'h0);
        rd(32'h0008, r); check("unmapped2", r, 32'h0);

        wr(CMP, 32'd7, 4'hF);
        wr(TMR, 32'd6, 4'hF);
        idle(2);
        check("irq_pre_rst", {31'h0, timer_irq}, 32'h1);
        rst = 1'b1;
        wr(LED, 32'h0000_ABCD, 4'hF);
        check("mid_rst_led", {16'h0, led}, 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_irq", {31'h0, timer_irq}, 32'h0);
        rst = 1'b0;
        rd(TMR, r);     check("mid_rst_timer", r, 32'h0);
        rd(CMP, r);     check("mid_rst_cmp", r, 32'hFFFF_FFFF);
        rd(LED, r);     check("mid_rst_ledreg", r, 32'h0);
        rd(S0, r);      check("mid_rst_s0", r, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
